updown_seq_decoder: RTL and testbench

Receive-side companion to the team's JK-based 3-bit up/down counter. Samples the counter's code stream on a strobe and recovers the counting direction (`mode`), a signed running position, wrap events and illegal-step errors. Sits downstream of the counter, or across a register boundary from it, as a monitor and position tracker.

---
 rtl/updown_seq_decoder.sv | 156 +++++++++++++++
 tb/tb_updown_seq_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_decoder.sv
// updown_seq_decoder
//
// Purpose: receive-side monitor for the JK-based 3-bit up/down counter. On each
// `sample` strobe it compares the observed code against the previously sampled
// one and recovers the counting direction, a signed running position, wrap
// events and illegal-step errors. Repeated illegal steps lock it into a sticky
// FAULT state that only `clr` leaves.
//
// Handshake: `sample` is a qualifier, not a valid/ready pair. `q_in` is used
// only in cycles where `sample` = 1. The block never back-pressures. Every
// output is registered and reflects a sample one clock after its edge.
//
// Parameters:
//   WIDTH     - code width of the observed counter value
//   POS_W     - width of the two's-complement position accumulator
//   ERR_LIMIT - consecutive illegal steps that force FAULT (1..15)
//
// Ports:
//   clk        in   clock, rising edge
//   clr        in   synchronous active-high reset, priority over sample
//   q_in       in   [WIDTH] observed counter code
//   sample     in   strobe qualifying q_in
//   mode_out   out  recovered direction (0 = up, 1 = down)
//   dir_valid  out  mode_out is meaningful (a legal step has been seen)
//   pos        out  [POS_W] signed running position, wraps modulo 2^POS_W
//   step       out  pulse per legal step
//   hold       out  pulse when the sampled code repeats
//   wrap       out  pulse on all-ones->0 (up) or 0->all-ones (down)
//   step_err   out  pulse per illegal step
//   fault      out  level, high while in FAULT
//   rev_cnt    out  [8] saturating direction-reversal count
//   dbg_state  out  [3] FSM state: 0 INIT, 1 ARMED, 2 UP, 3 DOWN, 4 FAULT
//
// Configuration macro: UPDOWN_DEC_REVCNT_EN. When it is undefined the reversal
// counter is not built and rev_cnt is tied to 0.

module updown_seq_decoder #(
    parameter int WIDTH     = 3,
    parameter int POS_W     = 8,
    parameter int ERR_LIMIT = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] q_in,
    input  logic             sample,
    output logic             mode_out,
    output logic             dir_valid,
    output logic [POS_W-1:0] pos,
    output logic             step,
    output logic             hold,
    output logic             wrap,
    output logic             step_err,
    output logic             fault,
    output logic [7:0]       rev_cnt,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_INIT  = 3'd0,
        S_ARMED = 3'd1,
        S_UP    = 3'd2,
        S_DOWN  = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [WIDTH-1:0] CODE_ONES = '1;
    localparam logic [WIDTH-1:0] CODE_ZERO = '0;
    localparam logic [WIDTH-1:0] CODE_ONE  = WIDTH'(1);
    localparam logic [POS_W-1:0] POS_ONE   = POS_W'(1);
    localparam logic [3:0]       ERR_LIM_4 = 4'(ERR_LIMIT);

    state_t           state;
    logic [WIDTH-1:0] last;
    logic [3:0]       ecnt;

    // Modular difference; the subtraction naturally wraps at WIDTH bits.
    logic [WIDTH-1:0] diff;
    logic             is_up;
    logic             is_down;
    logic             is_hold;
    logic [3:0]       ecnt_inc;

    assign diff     = q_in - last;
    assign is_up    = (diff == CODE_ONE);
    assign is_down  = (diff == CODE_ONES);
    assign is_hold  = (diff == CODE_ZERO);
    assign ecnt_inc = ecnt + 4'd1;

    assign dbg_state = state;

`ifndef UPDOWN_DEC_REVCNT_EN
    assign rev_cnt = 8'd0;
`endif

    always_ff @(posedge clk) begin
        // Pulses default low; they are raised only by the sample being handled.
        step     <= 1'b0;
        hold     <= 1'b0;
        wrap     <= 1'b0;
        step_err <= 1'b0;

        if (clr) begin
            state     <= S_INIT;
            last      <= '0;
            ecnt      <= '0;
            mode_out  <= 1'b0;
            dir_valid <= 1'b0;
            pos       <= '0;
            fault     <= 1'b0;
`ifdef UPDOWN_DEC_REVCNT_EN
            rev_cnt   <= 8'd0;
`endif
        end else if (sample) begin
            unique case (state)
                S_INIT: begin
                    last  <= q_in;
                    state <= S_ARMED;
                end
                S_ARMED, S_UP, S_DOWN: begin
                    last <= q_in;
                    if (is_up || is_down) begin
`ifdef UPDOWN_DEC_REVCNT_EN
                        // A reversal needs an established direction to reverse.
                        if (dir_valid && (mode_out != is_down) && (rev_cnt != 8'hFF))
                            rev_cnt <= rev_cnt + 8'd1;
`endif
                        pos       <= is_up ? pos + POS_ONE : pos - POS_ONE;
                        mode_out  <= is_down;
                        dir_valid <= 1'b1;
                        step      <= 1'b1;
                        ecnt      <= '0;
                        state     <= is_up ? S_UP : S_DOWN;
                        wrap      <= is_up ? (last == CODE_ONES && q_in == CODE_ZERO)
                                           : (last == CODE_ZERO && q_in == CODE_ONES);
                    end else if (is_hold) begin
                        hold <= 1'b1;
                    end else begin
                        step_err <= 1'b1;
                        ecnt     <= ecnt_inc;
                        if (ecnt_inc == ERR_LIM_4) begin
                            state     <= S_FAULT;
                            fault     <= 1'b1;
                            dir_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    // FAULT is sticky: samples are ignored until clr.
                    fault     <= 1'b1;
                    dir_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_updown_seq_decoder.sv
// Directed testbench for updown_seq_decoder (default parameters).
// Expected values are hand-derived from the decoder's behaviour description.

module tb_updown_seq_decoder;

    logic       clk;
    logic       clr;
    logic [2:0] q_in;
    logic       sample;
    logic       mode_out;
    logic       dir_valid;
    logic [7:0] pos;
    logic       step;
    logic       hold;
    logic       wrap;
    logic       step_err;
    logic       fault;
    logic [7:0] rev_cnt;
    logic [2:0] dbg_state;

    int tests_run;
    int tests_failed;
    int step_total;
    int wrap_total;
    int hold_total;
    int err_total;

`ifdef UPDOWN_DEC_REVCNT_EN
    localparam logic [7:0] EXP_REV = 8'd1;
`else
    localparam logic [7:0] EXP_REV = 8'd0;
`endif

    updown_seq_decoder #(.WIDTH(3), .POS_W(8), .ERR_LIMIT(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .q_in      (q_in),
        .sample    (sample),
        .mode_out  (mode_out),
        .dir_valid (dir_valid),
        .pos       (pos),
        .step      (step),
        .hold      (hold),
        .wrap      (wrap),
        .step_err  (step_err),
        .fault     (fault),
        .rev_cnt   (rev_cnt),
        .dbg_state (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one sampled code; outputs are looked at 1 ns after the edge.
    task automatic do_sample(input logic [2:0] v);
        q_in   = v;
        sample = 1'b1;
        @(posedge clk);
        #1;
        sample = 1'b0;
        step_total += int'(step);
        wrap_total += int'(wrap);
        hold_total += int'(hold);
        err_total  += int'(step_err);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
    endtask

    task automatic clear_totals();
        step_total = 0;
        wrap_total = 0;
        hold_total = 0;
        err_total  = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pos"},   32'(pos), 32'h0);
        check({tag, "_mode"},  32'(mode_out), 32'h0);
        check({tag, "_dv"},    32'(dir_valid), 32'h0);
        check({tag, "_pulse"}, 32'({step, hold, wrap, step_err}), 32'h0);
        check({tag, "_fault"}, 32'(fault), 32'h0);
        check({tag, "_rev"},   32'(rev_cnt), 32'h0);
        check({tag, "_state"}, 32'(dbg_state), 32'd0);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        clear_totals();
        clr    = 1'b1;
        sample = 1'b0;
        q_in   = 3'd0;
        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;

        // Reset values
        check_all_zero("reset");

        // Count up 0..7,0: first sample arms, eight legal up steps follow
        do_sample(3'd0);
        check("arm_step", 32'(step), 32'h0);
        check("arm_state", 32'(dbg_state), 32'd1);
        check("arm_dv", 32'(dir_valid), 32'h0);
        do_sample(3'd1);
        check("first_step", 32'(step), 32'h1);
        check("first_dv", 32'(dir_valid), 32'h1);
        for (int i = 2; i <= 7; i++) do_sample(3'(i));
        check("up_nowrap_yet", 32'(wrap_total), 32'd0);
        do_sample(3'd0);
        check("up_wrap_pulse", 32'(wrap), 32'h1);
        check("up_steps", 32'(step_total), 32'd8);
        check("up_wraps", 32'(wrap_total), 32'd1);
        check("up_pos", 32'(pos), 32'd8);
        check("up_mode", 32'(mode_out), 32'h0);
        check("up_state", 32'(dbg_state), 32'd2);

        // No sample: no pulses, no change
        @(posedge clk);
        #1;
        check("idle_pulse", 32'({step, hold, wrap, step_err}), 32'h0);
        check("idle_pos", 32'(pos), 32'd8);

        // 0 (hold), 7, 6, 5: reversal to down
        do_sample(3'd0);
        check("rev_hold", 32'(hold), 32'h1);
        check("rev_hold_pos", 32'(pos), 32'd8);
        do_sample(3'd7);
        check("down_wrap", 32'(wrap), 32'h1);
        check("down_mode", 32'(mode_out), 32'h1);
        do_sample(3'd6);
        do_sample(3'd5);
        check("down_pos", 32'(pos), 32'd5);
        check("down_state", 32'(dbg_state), 32'd3);
        check("down_rev", 32'(rev_cnt), 32'(EXP_REV));

        // Holds while ARMED
        do_clr();
        clear_totals();
        do_sample(3'd3);
        do_sample(3'd3);
        do_sample(3'd3);
        check("hold_count", 32'(hold_total), 32'd2);
        check("hold_pos", 32'(pos), 32'd0);
        check("hold_dv", 32'(dir_valid), 32'h0);
        check("hold_state", 32'(dbg_state), 32'd1);

        // Error accounting with ERR_LIMIT = 2
        do_clr();
        clear_totals();
        do_sample(3'd1);
        do_sample(3'd2);
        do_sample(3'd5);
        check("err1_pulse", 32'(step_err), 32'h1);
        check("err1_state", 32'(dbg_state), 32'd2);
        check("err1_fault", 32'(fault), 32'h0);
        do_sample(3'd6);
        check("err_recover_step", 32'(step), 32'h1);
        do_sample(3'd0);
        check("err2_pulse", 32'(step_err), 32'h1);
        check("err2_fault", 32'(fault), 32'h0);
        do_sample(3'd3);
        check("err3_pulse", 32'(step_err), 32'h1);
        check("fault_set", 32'(fault), 32'h1);
        check("fault_dv", 32'(dir_valid), 32'h0);
        check("fault_state", 32'(dbg_state), 32'd4);
        do_sample(3'd4);
        check("fault_ignore", 32'({step, hold, wrap, step_err}), 32'h0);
        check("fault_pos", 32'(pos), 32'd2);
        check("fault_sticky", 32'(fault), 32'h1);
        check("fault_errs", 32'(err_total), 32'd3);
        do_clr();
        check_all_zero("fault_clr");

        // 128 up steps: position wraps to 0x80 (-128)
        clear_totals();
        do_sample(3'd0);
        for (int i = 1; i <= 128; i++) do_sample(3'(i % 8));
        check("long_pos", 32'(pos), 32'h80);
        check("long_steps", 32'(step_total), 32'd128);
        check("long_errs", 32'(err_total), 32'd0);
        check("long_fault", 32'(fault), 32'h0);

        // clr and sample together: reset wins, next sample only arms
        q_in   = 3'd1;
        sample = 1'b1;
        clr    = 1'b1;
        @(posedge clk);
        #1;
        clr    = 1'b0;
        sample = 1'b0;
        check("clr_prio_pos", 32'(pos), 32'd0);
        check("clr_prio_step", 32'(step), 32'h0);
        check("clr_prio_state", 32'(dbg_state), 32'd0);
        do_sample(3'd2);
        check("rearm_step", 32'(step), 32'h0);
        check("rearm_state", 32'(dbg_state), 32'd1);
        check("rearm_pos", 32'(pos), 32'd0);
        do_sample(3'd3);
        check("rearm_next_step", 32'(step), 32'h1);
        check("rearm_next_pos", 32'(pos), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
